// File: rtl/param_regfile_sb.sv
// Parametrised two-read/one-write register file with a per-register busy
// scoreboard, an optional hard-wired zero register and optional write bypass.
module param_regfile_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  write_enable,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [ADDR_W-1:0]     read_addr_A,
  input  logic [ADDR_W-1:0]     read_addr_B,
  output logic [DATA_W-1:0]     read_data_A,
  output logic [DATA_W-1:0]     read_data_B,
  output logic                  busy_A,
  output logic                  busy_B,
  input  logic                  rsv_enable,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_stall,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              write_ok;
  logic              rsv_ok;
  logic              bypass_A;
  logic              bypass_B;

  // Address 0 is inert when the zero register is enabled.
  assign write_ok = write_enable && !RESET &&
                    !((ZERO_REG != 0) && (write_addr == '0));
  assign rsv_ok   = rsv_enable && !RESET &&
                    !((ZERO_REG != 0) && (rsv_addr == '0));

  // A write landing on the reserved entry this cycle frees it, so no stall.
  assign rsv_stall = rsv_enable && !RESET && busy[rsv_addr] &&
                     !(write_ok && (write_addr == rsv_addr));

  always_comb begin
    busy_next = busy;
    if (write_ok)
      busy_next[write_addr] = 1'b0;
    if (rsv_ok && !rsv_stall)
      busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      if (write_ok)
        regs[write_addr] <= write_data;
      busy <= busy_next;
    end
  end

  assign bypass_A = (BYPASS != 0) && write_ok && (write_addr == read_addr_A);
  assign bypass_B = (BYPASS != 0) && write_ok && (write_addr == read_addr_B);

  always_comb begin
    if ((ZERO_REG != 0) && (read_addr_A == '0))
      read_data_A = '0;
    else if (bypass_A)
      read_data_A = write_data;
    else
      read_data_A = regs[read_addr_A];

    if ((ZERO_REG != 0) && (read_addr_B == '0))
      read_data_B = '0;
    else if (bypass_B)
      read_data_B = write_data;
    else
      read_data_B = regs[read_addr_B];
  end

  assign busy_A   = bypass_A ? 1'b0 : busy[read_addr_A];
  assign busy_B   = bypass_B ? 1'b0 : busy[read_addr_B];
  assign busy_vec = busy;

endmodule

// File: tb/tb_param_regfile_sb.sv
// Directed bench for param_regfile_sb across four parameter configurations.
module tb_param_regfile_sb;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Shared stimulus for the three 16x8 instances.
  logic        we, rsv_en;
  logic [2:0]  wa, ra, rb, rsv_a;
  logic [15:0] wd;

  logic [15:0] b_rda, b_rdb, n_rda, n_rdb, z_rda, z_rdb;
  logic        b_ba, b_bb, b_st, n_ba, n_bb, n_st, z_ba, z_bb, z_st;
  logic [7:0]  b_vec, n_vec, z_vec;

  logic        w_we, w_rsv_en;
  logic [4:0]  w_wa, w_ra, w_rb, w_rsv_a;
  logic [31:0] w_wd, w_rda, w_rdb, w_vec;
  logic        w_ba, w_bb, w_st;

  param_regfile_sb u_byp (
    .clk(clk), .RESET(RESET), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_addr_A(ra), .read_addr_B(rb), .read_data_A(b_rda), .read_data_B(b_rdb),
    .busy_A(b_ba), .busy_B(b_bb), .rsv_enable(rsv_en), .rsv_addr(rsv_a),
    .rsv_stall(b_st), .busy_vec(b_vec));

  param_regfile_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .RESET(RESET), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_addr_A(ra), .read_addr_B(rb), .read_data_A(n_rda), .read_data_B(n_rdb),
    .busy_A(n_ba), .busy_B(n_bb), .rsv_enable(rsv_en), .rsv_addr(rsv_a),
    .rsv_stall(n_st), .busy_vec(n_vec));

  param_regfile_sb #(.ZERO_REG(1)) u_zero (
    .clk(clk), .RESET(RESET), .write_enable(we), .write_addr(wa), .write_data(wd),
    .read_addr_A(ra), .read_addr_B(rb), .read_data_A(z_rda), .read_data_B(z_rdb),
    .busy_A(z_ba), .busy_B(z_bb), .rsv_enable(rsv_en), .rsv_addr(rsv_a),
    .rsv_stall(z_st), .busy_vec(z_vec));

  param_regfile_sb #(.DATA_W(32), .ADDR_W(5)) u_wide (
    .clk(clk), .RESET(RESET), .write_enable(w_we), .write_addr(w_wa), .write_data(w_wd),
    .read_addr_A(w_ra), .read_addr_B(w_rb), .read_data_A(w_rda), .read_data_B(w_rdb),
    .busy_A(w_ba), .busy_B(w_bb), .rsv_enable(w_rsv_en), .rsv_addr(w_rsv_a),
    .rsv_stall(w_st), .busy_vec(w_vec));

  task automatic idle();
    we = 0; wa = 0; wd = 0; ra = 0; rb = 0; rsv_en = 0; rsv_a = 0;
    w_we = 0; w_wa = 0; w_wd = 0; w_ra = 0; w_rb = 0; w_rsv_en = 0; w_rsv_a = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow #1 later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); RESET = 1; step(); RESET = 0;
  endtask

  task automatic test_reset();
    do_reset();
    we = 1; wa = 5; wd = 16'hBEEF; rsv_en = 1; rsv_a = 2;
    step(); idle(); ra = 5; #1;
    checks++; if (b_rda !== 16'hBEEF) begin errors++; $display("FAIL pre_reset_r5: got %h want BEEF", b_rda); end
    checks++; if (b_vec !== 8'h04) begin errors++; $display("FAIL pre_reset_vec: got %h want 04", b_vec); end
    RESET = 1; we = 1; wa = 1; wd = 16'h1111; rsv_en = 1; rsv_a = 3; #1;
    checks++; if (b_st !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", b_st); end
    step(); RESET = 0; idle(); ra = 5; rb = 1; #1;
    checks++; if (b_rda !== 16'h0000) begin errors++; $display("FAIL reset_r5: got %h want 0000", b_rda); end
    checks++; if (b_rdb !== 16'h0000) begin errors++; $display("FAIL reset_discard_write: got %h want 0000", b_rdb); end
    checks++; if (b_vec !== 8'h00) begin errors++; $display("FAIL reset_vec: got %h want 00", b_vec); end
  endtask

  task automatic test_write_bypass();
    do_reset();
    we = 1; wa = 3; wd = 16'h1234; ra = 3; #1;
    checks++; if (b_rda !== 16'h1234) begin errors++; $display("FAIL bypass_same_cycle: got %h want 1234", b_rda); end
    checks++; if (n_rda !== 16'h0000) begin errors++; $display("FAIL nobypass_old: got %h want 0000", n_rda); end
    step(); idle(); ra = 3; rb = 3; #1;
    checks++; if (n_rda !== 16'h1234) begin errors++; $display("FAIL nobypass_next: got %h want 1234", n_rda); end
    checks++; if (b_rdb !== 16'h1234) begin errors++; $display("FAIL read_b_same_reg: got %h want 1234", b_rdb); end
    checks++; if (b_vec !== 8'h00) begin errors++; $display("FAIL write_unbusy_vec: got %h want 00", b_vec); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rsv_en = 1; rsv_a = 4; #1;
    checks++; if (b_st !== 1'b0) begin errors++; $display("FAIL rsv_first_stall: got %b want 0", b_st); end
    step(); rsv_en = 0; ra = 4; #1;
    checks++; if (b_vec !== 8'h10) begin errors++; $display("FAIL rsv_vec: got %h want 10", b_vec); end
    checks++; if (b_ba !== 1'b1) begin errors++; $display("FAIL rsv_busy_a: got %b want 1", b_ba); end
    rsv_en = 1; rsv_a = 4; #1;
    checks++; if (b_st !== 1'b1) begin errors++; $display("FAIL rsv_again_stall: got %b want 1", b_st); end
    step(); rsv_en = 0; #1;
    checks++; if (b_vec !== 8'h10) begin errors++; $display("FAIL stall_vec: got %h want 10", b_vec); end
    we = 1; wa = 4; wd = 16'h00AA; ra = 4; #1;
    checks++; if (b_ba !== 1'b0) begin errors++; $display("FAIL bypass_busy_a: got %b want 0", b_ba); end
    checks++; if (n_ba !== 1'b1) begin errors++; $display("FAIL nobypass_busy_a: got %b want 1", n_ba); end
    step(); idle(); ra = 4; #1;
    checks++; if (b_vec !== 8'h00) begin errors++; $display("FAIL write_clear_vec: got %h want 00", b_vec); end
    checks++; if (n_rda !== 16'h00AA) begin errors++; $display("FAIL write_r4: got %h want 00AA", n_rda); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsv_en = 1; rsv_a = 6; step();
    rsv_en = 1; rsv_a = 6; we = 1; wa = 6; wd = 16'h5555; #1;
    checks++; if (b_st !== 1'b0) begin errors++; $display("FAIL simul_stall: got %b want 0", b_st); end
    step(); idle(); ra = 6; #1;
    checks++; if (n_rda !== 16'h5555) begin errors++; $display("FAIL simul_r6: got %h want 5555", n_rda); end
    checks++; if (b_vec !== 8'h40) begin errors++; $display("FAIL simul_vec: got %h want 40", b_vec); end
    we = 1; wa = 1; wd = 16'h0101; rsv_en = 1; rsv_a = 2; step(); idle(); #1;
    checks++; if (b_vec !== 8'h44) begin errors++; $display("FAIL indep_vec: got %h want 44", b_vec); end
    rsv_en = 1; rsv_a = 6; we = 1; wa = 2; wd = 16'h2222; #1;
    checks++; if (b_st !== 1'b1) begin errors++; $display("FAIL other_write_stall: got %b want 1", b_st); end
    step(); idle(); #1;
    checks++; if (b_vec !== 8'h40) begin errors++; $display("FAIL other_write_vec: got %h want 40", b_vec); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    we = 1; wa = 0; wd = 16'hFFFF; rsv_en = 1; rsv_a = 0; rb = 0; #1;
    checks++; if (z_rdb !== 16'h0000) begin errors++; $display("FAIL zero_bypass: got %h want 0000", z_rdb); end
    checks++; if (z_st !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", z_st); end
    step(); we = 0; rsv_en = 1; rsv_a = 0; #1;
    checks++; if (z_rdb !== 16'h0000) begin errors++; $display("FAIL zero_read: got %h want 0000", z_rdb); end
    checks++; if (z_bb !== 1'b0) begin errors++; $display("FAIL zero_busy_b: got %b want 0", z_bb); end
    checks++; if (z_vec !== 8'h00) begin errors++; $display("FAIL zero_vec: got %h want 00", z_vec); end
    checks++; if (z_st !== 1'b0) begin errors++; $display("FAIL zero_restall: got %b want 0", z_st); end
    checks++; if (b_rdb !== 16'hFFFF) begin errors++; $display("FAIL nonzero_r0: got %h want FFFF", b_rdb); end
    checks++; if (b_vec !== 8'h01) begin errors++; $display("FAIL nonzero_vec: got %h want 01", b_vec); end
    idle();
  endtask

  task automatic test_wide();
    do_reset();
    w_we = 1; w_wa = 31; w_wd = 32'hDEADBEEF; w_ra = 31; w_rb = 31; #1;
    checks++; if (w_rdb !== 32'hDEADBEEF) begin errors++; $display("FAIL wide_bypass_b: got %h want DEADBEEF", w_rdb); end
    step(); w_we = 0; #1;
    checks++; if (w_rda !== 32'hDEADBEEF) begin errors++; $display("FAIL wide_a: got %h want DEADBEEF", w_rda); end
    checks++; if (w_rdb !== 32'hDEADBEEF) begin errors++; $display("FAIL wide_b: got %h want DEADBEEF", w_rdb); end
    w_rsv_en = 1; w_rsv_a = 31; step(); w_rsv_en = 0; #1;
    checks++; if (w_vec !== 32'h80000000) begin errors++; $display("FAIL wide_vec: got %h want 80000000", w_vec); end
    checks++; if (w_ba !== 1'b1) begin errors++; $display("FAIL wide_busy_a: got %b want 1", w_ba); end
  endtask

  initial begin
    RESET = 0;
    idle();
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_back_to_back();
    test_zero_reg();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
